multicycle_control: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It sits directly upstream of the ALU control stage and drives ALUOp1/ALUOp0 into it. It sequences each instruction through fetch, decode, execute, memory and writeback. It also produces every datapath enable and mux select as Moore outputs decoded from the current state.

---
 rtl/multicycle_control.sv | 140 ++++++++++++++
 tb/tb_multicycle_control.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Moore outputs are decoded from the state register and held at 0 while reset is high.
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic       ALUOp1,
    output logic       ALUOp0,
    output logic [1:0] ALUSrcB,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9
    } state_t;

    // Kept as a plain vector so the unused codes 10-15 stay representable.
    logic [3:0] r_state;
    state_t     w_next;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (state_t'(r_state))
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (Op == OP_LW || Op == OP_SW) w_next = S_MEMADDR;
                else if (Op == OP_RTYPE)        w_next = S_EXECUTE;
                else if (Op == OP_BEQ)          w_next = S_BRANCH;
                else if (Op == OP_J)            w_next = S_JUMP;
                else                            w_next = S_FETCH;
            end
            // An opcode change after DECODE is outside the contract; fall back to FETCH.
            S_MEMADDR: begin
                if (Op == OP_LW)      w_next = S_MEMRD;
                else if (Op == OP_SW) w_next = S_MEMWR;
                else                  w_next = S_FETCH;
            end
            S_MEMRD:   w_next = S_MEMWB;
            S_EXECUTE: w_next = S_RWB;
            default:   w_next = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = 2'b00;
        ALUOp1      = 1'b0;
        ALUOp0      = 1'b0;
        ALUSrcB     = 2'b00;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        state       = 4'd0;
        if (!reset) begin
            state = r_state;
            case (state_t'(r_state))
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    ALUSrcB = 2'b01;
                    PCWrite = 1'b1;
                end
                S_DECODE:  ALUSrcB = 2'b11;
                S_MEMADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp1  = 1'b1;
                end
                S_RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp0      = 1'b1;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus hand-written corner sequences.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Op = 6'd0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0] PCSource, ALUSrcB;
    logic       ALUOp1, ALUOp0, ALUSrcA, RegWrite, RegDst;
    logic [3:0] state;

    int n_total = 0;
    int n_pass  = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .Op(Op),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp1(ALUOp1),
        .ALUOp0(ALUOp0), .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA),
        .RegWrite(RegWrite), .RegDst(RegDst), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ILL = 6'b111111;

    // Output word: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,PCSource,ALUOp,ALUSrcB,ALUSrcA,RegWrite,RegDst
    function automatic logic [15:0] mk(logic pcw, logic pcwc, logic iord, logic mr, logic mw,
                                       logic m2r, logic irw, logic [1:0] pcs, logic [1:0] aop,
                                       logic [1:0] srcb, logic srca, logic rw, logic rd);
        return {pcw, pcwc, iord, mr, mw, m2r, irw, pcs, aop, srcb, srca, rw, rd};
    endfunction

    logic [15:0] O_F, O_D, O_MA, O_MR, O_MWB, O_MWR, O_EX, O_RWB, O_BR, O_J, O_Z;
    initial begin
        O_F   = mk(1,0,0,1,0,0,1,2'b00,2'b00,2'b01,0,0,0);
        O_D   = mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b11,0,0,0);
        O_MA  = mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0,0);
        O_MR  = mk(0,0,1,1,0,0,0,2'b00,2'b00,2'b00,0,0,0);
        O_MWB = mk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,1,0);
        O_MWR = mk(0,0,1,0,1,0,0,2'b00,2'b00,2'b00,0,0,0);
        O_EX  = mk(0,0,0,0,0,0,0,2'b00,2'b10,2'b00,1,0,0);
        O_RWB = mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,1);
        O_BR  = mk(0,1,0,0,0,0,0,2'b01,2'b01,2'b00,1,0,0);
        O_J   = mk(1,0,0,0,0,0,0,2'b10,2'b00,2'b00,0,0,0);
        O_Z   = 16'h0000;
    end

    wire [15:0] outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                        PCSource, ALUOp1, ALUOp0, ALUSrcB, ALUSrcA, RegWrite, RegDst};

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [3:0]  st;
        logic [15:0] o;
    } vec_t;

    task automatic chk(string name, logic [3:0] exp_st, logic [15:0] exp_o);
        n_total++;
        if (state === exp_st && outs === exp_o) n_pass++;
        else $display("FAIL %s: got state=%0d outs=%b, want state=%0d outs=%b",
                      name, state, outs, exp_st, exp_o);
    endtask

    // Exclusivity invariants, checked on every falling edge.
    always @(negedge clk) begin
        n_total++;
        if (!(MemRead && MemWrite) && !(RegWrite && MemWrite) && !(PCWrite && PCWriteCond))
            n_pass++;
        else $display("FAIL invariant: MemRead=%b MemWrite=%b RegWrite=%b PCWrite=%b PCWriteCond=%b, want no conflicting pair",
                      MemRead, MemWrite, RegWrite, PCWrite, PCWriteCond);
    end

    vec_t tbl[$];

    initial begin
        #1;
        tbl = '{
            '{1'b1, RT,  4'd0, O_Z}, '{1'b1, RT,  4'd0, O_Z}, '{1'b1, RT,  4'd0, O_Z},
            '{1'b0, LW,  4'd0, O_F}, '{1'b0, LW,  4'd1, O_D}, '{1'b0, LW,  4'd2, O_MA},
            '{1'b0, LW,  4'd3, O_MR}, '{1'b0, LW,  4'd4, O_MWB},
            '{1'b0, SW,  4'd0, O_F}, '{1'b0, SW,  4'd1, O_D}, '{1'b0, SW,  4'd2, O_MA},
            '{1'b0, SW,  4'd5, O_MWR},
            '{1'b0, RT,  4'd0, O_F}, '{1'b0, RT,  4'd1, O_D}, '{1'b0, RT,  4'd6, O_EX},
            '{1'b0, RT,  4'd7, O_RWB},
            '{1'b0, BEQ, 4'd0, O_F}, '{1'b0, BEQ, 4'd1, O_D}, '{1'b0, BEQ, 4'd8, O_BR},
            '{1'b0, JMP, 4'd0, O_F}, '{1'b0, JMP, 4'd1, O_D}, '{1'b0, JMP, 4'd9, O_J},
            '{1'b0, ILL, 4'd0, O_F}, '{1'b0, ILL, 4'd1, O_D},
            '{1'b0, LW,  4'd0, O_F}
        };
        // Inputs change just after the rising edge; outputs are checked on the falling edge.
        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            Op    = tbl[i].op;
            @(negedge clk);
            chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].o);
            @(posedge clk); #1;
        end

        // Illegal state code 12: all outputs 0, FETCH afterwards.
        // Now in DECODE with Op=LW; overwrite the state register mid-cycle.
        @(negedge clk);
        chk("decode_before_force", 4'd1, O_D);
        dut.r_state = 4'd12;
        #1;
        chk("illegal_state12", 4'd12, O_Z);
        @(posedge clk); #1;
        @(negedge clk);
        chk("illegal_to_fetch", 4'd0, O_F);

        // Mid-instruction reset during MEMRD of a lw.
        Op = LW;
        @(posedge clk); #1;
        @(negedge clk); chk("lw2_decode", 4'd1, O_D);
        @(posedge clk); #1;
        @(negedge clk); chk("lw2_memaddr", 4'd2, O_MA);
        @(posedge clk); #1;
        @(negedge clk); chk("lw2_memrd", 4'd3, O_MR);
        reset = 1'b1;
        #1;
        chk("reset_in_memrd", 4'd0, O_Z);
        @(posedge clk); #1;
        @(negedge clk); chk("reset_held", 4'd0, O_Z);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); chk("after_reset_fetch", 4'd0, O_F);
        @(posedge clk); #1;
        @(negedge clk); chk("after_reset_decode", 4'd1, O_D);

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
